// File: rtl/argmax_classifier.sv
// rtl/argmax_classifier.sv - sequential argmax over OC signed Q8.8 class scores
// Reports winning index, its score and the margin to the runner-up over a valid/ready handshake.
module argmax_classifier #(
  parameter int OC            = 10,
  parameter int MARGIN_THRESH = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scores_valid,
  input  logic signed [15:0]    scores [0:OC-1],
  input  logic                  result_ready,
  output logic                  result_valid,
  output logic [$clog2(OC)-1:0] class_idx,
  output logic signed [15:0]    max_score,
  output logic signed [16:0]    margin,
  output logic                  low_conf,
  output logic                  busy
);

  localparam int IW = $clog2(OC);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t             state_q, state_d;
  logic signed [15:0] score_buf [0:OC-1];
  logic signed [15:0] best_q, second_q, best_d, second_d, cur;
  logic [IW-1:0]      idx_q, best_idx_q, best_idx_d;
  logic               armed_q, capture, last;
  logic signed [16:0] margin_d;
  logic               low_conf_d;

  always_comb begin
    state_d    = state_q;
    capture    = 1'b0;
    cur        = score_buf[idx_q];
    best_d     = best_q;
    second_d   = second_q;
    best_idx_d = best_idx_q;
    last       = (idx_q == IW'(OC - 1));
    case (state_q)
      IDLE: begin
        if (scores_valid && armed_q) begin
          capture = 1'b1;
          state_d = SCAN;
        end
      end
      SCAN: begin
        // Strict compares: on a tie the lower index keeps the win and the tie becomes second.
        if (cur > best_q) begin
          second_d   = best_q;
          best_d     = cur;
          best_idx_d = idx_q;
        end else if (cur > second_q) begin
          second_d = cur;
        end
        if (last) state_d = DONE;
      end
      DONE: begin
        if (result_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    margin_d   = {best_d[15], best_d} - {second_d[15], second_d};
    low_conf_d = (margin_d < $signed(17'(MARGIN_THRESH)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < OC; i++) score_buf[i] <= '0;
      best_q       <= '0;
      second_q     <= '0;
      best_idx_q   <= '0;
      idx_q        <= '0;
      armed_q      <= 1'b0;
      result_valid <= 1'b0;
      class_idx    <= '0;
      max_score    <= '0;
      margin       <= '0;
      low_conf     <= 1'b0;
    end else begin
      // A level held high must drop once before it can trigger another capture.
      if (!scores_valid) armed_q <= 1'b1;
      else if (capture)  armed_q <= 1'b0;

      if (capture) begin
        for (int i = 0; i < OC; i++) score_buf[i] <= scores[i];
        best_q     <= scores[0];
        best_idx_q <= '0;
        second_q   <= 16'sh8000;
        idx_q      <= IW'(1);
      end

      if (state_q == SCAN) begin
        best_q     <= best_d;
        second_q   <= second_d;
        best_idx_q <= best_idx_d;
        if (last) begin
          class_idx    <= best_idx_d;
          max_score    <= best_d;
          margin       <= margin_d;
          low_conf     <= low_conf_d;
          result_valid <= 1'b1;
        end else begin
          idx_q <= idx_q + IW'(1);
        end
      end

      if (state_q == DONE && result_ready) result_valid <= 1'b0;
    end
  end

  assign busy = (state_q == SCAN) || (state_q == DONE);

endmodule

// File: tb/tb_argmax_classifier.sv
// tb/tb_argmax_classifier.sv - directed self-checking bench for argmax_classifier
module tb_argmax_classifier;

  logic               clk = 1'b0;
  logic               rst;
  logic               scores_valid;
  logic signed [15:0] scores [0:9];
  logic               result_ready;
  logic               result_valid;
  logic [3:0]         class_idx;
  logic signed [15:0] max_score;
  logic signed [16:0] margin;
  logic               low_conf;
  logic               busy;

  int n_cmp = 0;
  int n_err = 0;

  argmax_classifier #(.OC(10), .MARGIN_THRESH(256)) dut (
    .clk(clk), .rst(rst), .scores_valid(scores_valid), .scores(scores),
    .result_ready(result_ready), .result_valid(result_valid), .class_idx(class_idx),
    .max_score(max_score), .margin(margin), .low_conf(low_conf), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_result(output int n);
    n = 0;
    while (!result_valid && n < 30) begin
      step();
      n++;
    end
  endtask

  task automatic check_result(input string tag, input int lat, input int idx, input int mx, input int mg, input logic lc);
    n_cmp++; if (lat !== 9) begin n_err++; $display("FAIL %s latency: got %0d want 9", tag, lat); end
    n_cmp++; if (class_idx !== 4'(idx)) begin n_err++; $display("FAIL %s class_idx: got %0d want %0d", tag, class_idx, idx); end
    n_cmp++; if (max_score !== 16'(mx)) begin n_err++; $display("FAIL %s max_score: got %0d want %0d", tag, max_score, mx); end
    n_cmp++; if (margin !== 17'(mg)) begin n_err++; $display("FAIL %s margin: got %0d want %0d", tag, margin, mg); end
    n_cmp++; if (low_conf !== lc) begin n_err++; $display("FAIL %s low_conf: got %0b want %0b", tag, low_conf, lc); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL %s busy_done: got %0b want 1", tag, busy); end
  endtask

  task automatic accept(input string tag);
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    n_cmp++; if (result_valid !== 1'b0) begin n_err++; $display("FAIL %s accept_valid: got %0b want 0", tag, result_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL %s accept_busy: got %0b want 0", tag, busy); end
  endtask

  task automatic capture_run(input logic signed [15:0] v [0:9], output int lat);
    scores_valid = 1'b0;
    step();
    scores = v;
    scores_valid = 1'b1;
    step();
    n_cmp++; if (busy !== 1'b1 || result_valid !== 1'b0) begin n_err++; $display("FAIL capture_state: got busy=%0b valid=%0b want busy=1 valid=0", busy, result_valid); end
    wait_result(lat);
  endtask

  task automatic test_reset();
    rst = 1'b1; scores_valid = 1'b0; result_ready = 1'b0;
    for (int i = 0; i < 10; i++) scores[i] = '0;
    step(); step();
    n_cmp++; if ({result_valid, busy, low_conf} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {result_valid, busy, low_conf}); end
    n_cmp++; if (class_idx !== 4'd0 || max_score !== 16'sd0 || margin !== 17'sd0) begin n_err++; $display("FAIL reset_data: got idx=%0d max=%0d mg=%0d want 0", class_idx, max_score, margin); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    logic signed [15:0] v [0:9];
    int lat;
    v = '{16'sd5, -16'sd3, 16'sd40, 16'sd12, 16'sd0, 16'sd7, -16'sd100, 16'sd39, 16'sd1, 16'sd2};
    capture_run(v, lat);
    check_result("basic", lat, 2, 40, 1, 1'b1);
    accept("basic");
  endtask

  task automatic test_tie_conf();
    logic signed [15:0] v [0:9];
    int lat;
    v = '{16'sd0, 16'sd0, 16'sd0, 16'sd768, 16'sd768, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
    capture_run(v, lat);
    check_result("tie", lat, 3, 768, 0, 1'b1);
    accept("tie");
    v = '{16'sd512, -16'sd256, -16'sd256, -16'sd256, -16'sd256, -16'sd256, -16'sd256, -16'sd256, -16'sd256, -16'sd256};
    capture_run(v, lat);
    check_result("conf", lat, 0, 512, 768, 1'b0);
    accept("conf");
  endtask

  task automatic test_extremes_handshake();
    logic signed [15:0] v [0:9];
    int lat;
    for (int i = 0; i < 9; i++) v[i] = 16'sh8000;
    v[9] = 16'sh7fff;
    capture_run(v, lat);
    check_result("extreme", lat, 9, 32767, 65535, 1'b0);
    for (int c = 0; c < 5; c++) begin
      for (int i = 0; i < 10; i++) scores[i] = 16'($urandom_range(0, 65535));
      step();
      n_cmp++;
      if (result_valid !== 1'b1 || class_idx !== 4'd9 || max_score !== 16'sd32767 || margin !== 17'sd65535) begin
        n_err++;
        $display("FAIL hold_%0d: got v=%0b idx=%0d max=%0d mg=%0d want v=1 idx=9 max=32767 mg=65535", c, result_valid, class_idx, max_score, margin);
      end
    end
    accept("extreme");
  endtask

  task automatic test_rearm();
    logic signed [15:0] v [0:9];
    int lat;
    for (int c = 0; c < 4; c++) step();
    n_cmp++; if (busy !== 1'b0 || result_valid !== 1'b0) begin n_err++; $display("FAIL held_level_recapture: got busy=%0b valid=%0b want 0 0", busy, result_valid); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) step();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_level_recapture: got busy=%0b want 0", busy); end
    v = '{16'sd100, 16'sd200, -16'sd50, 16'sd300, 16'sd250, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd10};
    capture_run(v, lat);
    check_result("rearm", lat, 3, 300, 50, 1'b1);
    accept("rearm");
  endtask

  task automatic test_reset_mid_scan();
    logic signed [15:0] v [0:9];
    int lat;
    v = '{16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd5, 16'sd6, 16'sd7, 16'sd8, 16'sd9, 16'sd1000};
    scores_valid = 1'b0;
    step();
    scores = v;
    scores_valid = 1'b1;
    for (int c = 0; c < 4; c++) step();
    #2 rst = 1'b1;
    #1;
    n_cmp++; if ({result_valid, busy, low_conf} !== 3'b000) begin n_err++; $display("FAIL async_flags: got %b want 000", {result_valid, busy, low_conf}); end
    n_cmp++; if (class_idx !== 4'd0 || max_score !== 16'sd0 || margin !== 17'sd0) begin n_err++; $display("FAIL async_data: got idx=%0d max=%0d mg=%0d want 0", class_idx, max_score, margin); end
    step();
    rst = 1'b0;
    v = '{-16'sd1000, -16'sd900, -16'sd800, -16'sd700, -16'sd600, -16'sd500, -16'sd400, -16'sd300, -16'sd200, 16'sd600};
    capture_run(v, lat);
    check_result("post_reset", lat, 9, 600, 800, 1'b0);
    accept("post_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tie_conf();
    test_extremes_handshake();
    test_rearm();
    test_reset_mid_scan();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/argmax_classifier.md
Name: argmax_classifier

Overview:
Final classification stage placed directly downstream of the fully-connected output layer. Captures the OC signed Q8.8 class scores when the FC layer signals completion. Scans the scores sequentially, one per cycle, and reports the winning class index, its score, and the margin to the runner-up. Results are presented on a valid/ready handshake to the host-side result logic (UART/display).

Parameters:
OC, 10, number of class scores; must be >= 2
MARGIN_THRESH, 256, Q8.8 margin (1.0) below which the result is flagged low-confidence

Ports:
clk  in  1  system clock, rising-edge
rst  in  1  asynchronous, active-high reset
scores_valid  in  1  level from FC data_out_ready; scores stable while high
scores  in  16 x OC (signed, unpacked [0:OC-1])  Q8.8 class scores
result_ready  in  1  consumer accepts result
result_valid  out  1  result outputs valid
class_idx  out  $clog2(OC)  winning class index
max_score  out  16 signed  winning score
margin  out  17 signed  max_score minus second-best score, always >= 0
low_conf  out  1  margin < MARGIN_THRESH
busy  out  1  high in SCAN and DONE

Behaviour:
- Reset (async, rst=1): state=IDLE; result_valid=0, class_idx=0, max_score=0, margin=0, low_conf=0, busy=0; armed=0; score buffer cleared. Reset asserted mid-SCAN or in DONE aborts immediately and discards the partial result.
- armed flag: set on any clock edge where scores_valid=0; cleared on capture. A scores_valid level held high across reset does not trigger a capture until it has dropped low once.
- States:
  - IDLE: if scores_valid && armed, then:
    - copy all scores into the internal buffer;
    - best=scores[0], best_idx=0, second=-32768, i=1, armed=0;
    - go to SCAN.
  - SCAN: each cycle examine buf[i], with s=buf[i]:
    - if s > best: second=best, best=s, best_idx=i;
    - else if s > second: second=s.
    - All comparisons are strictly signed.
    - When i==OC-1, update and go to DONE in the same edge. Register class_idx, max_score, margin (17-bit sign-extended subtraction best-second) and low_conf from the final values, and set result_valid=1.
    - Otherwise i=i+1.
  - DONE: outputs held stable while result_valid=1. On an edge with result_ready=1: result_valid=0, go to IDLE. Output registers keep their last values.
- Ties: strict > means the lowest index wins. A tied score becomes second, so margin=0 and low_conf=1.
- Latency: capture edge at cycle k; result_valid high from the cycle after edge k+OC-1 (OC=10: 9 clocks after capture). Input is not re-read after capture; upstream may change scores once result_valid is seen.
- Back-to-back: if scores_valid stays high through DONE without dropping, no recapture (armed=0). If it drops and rises while the block is busy, the capture occurs on the first IDLE cycle with scores_valid=1. A full low-high-low pulse that occurs entirely while busy is lost; upstream must hold the level, as the FC layer does.
- result_ready in IDLE/SCAN is ignored.
- busy=1 exactly in SCAN and DONE.
- Margin range is 0..65535; it never overflows.

Test Plan:
- Basic: scores {5,-3,40,12,0,7,-100,39,1,2}, scores_valid 0→1 → after 9 clocks result_valid=1, class_idx=2, max_score=40, margin=1, low_conf=1 (MARGIN_THRESH=256).
- Tie + confidence: scores {0,0,0,768,768,0,...}, then {512,...others -256} → first gives class_idx=3, margin=0, low_conf=1; second gives class_idx=0, margin=768, low_conf=0.
- Extremes: all scores -32768 except index 9 = 32767 → class_idx=9, max_score=32767, margin=65535 (17-bit, positive).
- Handshake: hold result_ready=0 for 5 cycles with scores changing → outputs unchanged, result_valid stays 1. Raise result_ready for one cycle → result_valid=0 next cycle, busy=0.
- Rearm: keep scores_valid high after accept → no new result. Drop it for 1 cycle, raise with new scores → new result after 9 clocks. Raise rst with scores_valid=1 → no capture until scores_valid toggles low.
- Reset mid-SCAN: assert rst at scan cycle 4 → all outputs 0 immediately (asynchronous). After release, a fresh low→high capture produces a correct, uncorrupted result.
